display_scheduler: RTL and testbench
====================================

# display_scheduler

Sequences the 8-digit scoreboard display. It rotates through the game-statistic pages on a timer, accepts a manual page-advance pulse, and pre-empts the rotation with timed alert messages that are buffered one deep. It sits between the game core and the Scoreboard/Decompose display path. It drives `disp_value`, the number to decompose, plus page and blank status.

## Interface
- `TICK_DIV`, default 200000: clk cycles per scheduler tick.
- `PAGE_TICKS`, default 1000: ticks each page is shown.
- `ALERT_TICKS`, default 2000: ticks each alert is shown.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  display enable; low forces state OFF.
- `page_mask`  in  7  bit i=1 means page i is in the rotation.
- `next_req`  in  1  one-cycle pulse: advance to the next enabled page now.
- `alert_req`  in  1  one-cycle pulse: show `alert_code`.
- `alert_code`  in  21  alert value, sampled in the cycle `alert_req`=1.
- `combo`, `base_score`, `bonus_score`, `acc`  in  21 each  pages 0–3.
- `mod`  in  2  page 4.
- `difficulty`  in  4  page 5.
- `level`  in  3  page 6.
- `disp_value`  out  21  registered value to display; narrower sources are zero-extended.
- `page_sel`  out  3  current page index, 0–6.
- `alert_active`  out  1  high while an alert is displayed.
- `blank`  out  1  high means the display must be dark.
- `alert_ack`  out  1  one-cycle pulse: the alert was accepted, either displayed or queued.
- `alert_drop`  out  1  one-cycle pulse: the alert was rejected because the queue is full.

## Operation
- States: OFF, SHOW, ALERT.
- Reset: state OFF, `disp_value`=0, `page_sel`=0, `alert_active`=0, `blank`=1, `alert_ack`=0, `alert_drop`=0. The tick counter, page timer, alert timer and pending slot are all cleared.
- Tick counter: counts 0..`TICK_DIV`-1 in SHOW and ALERT only. `tick` is asserted in the cycle the counter wraps.
- OFF → SHOW: on the first cycle with `en`=1. `page_sel` loads the lowest set bit of `page_mask`, or 0 if the mask is empty. Timers restart from 0.
- Any state → OFF: on any cycle with `en`=0. This clears every timer, the pending slot and `alert_active`, and sets `blank`=1. `alert_req` is ignored while `en`=0.
- SHOW, page timing: the page timer counts ticks. When the tick arrives with the timer at `PAGE_TICKS`-1, the timer goes to 0 and the page advances.
- Advance rule: `page_sel` moves to the next index above the current one whose mask bit is set, wrapping 6→0 and searching at most 7 positions.
  - If the current page is the only enabled page, `page_sel` is unchanged.
  - If `page_mask`=0, `page_sel` holds and `blank`=1.
- SHOW, manual advance: `next_req` advances immediately and clears the page timer. If `next_req` coincides with a page timeout, the page advances exactly once.
- SHOW, `blank`: 1 only when `page_mask`=0, otherwise 0. `page_mask` changes take effect at the next advance; the current page is not re-validated.
- SHOW → ALERT on `alert_req`: `alert_code` is latched as current, `alert_ack` pulses, the alert timer clears, and `alert_active`=1. The page timer and `page_sel` freeze. `next_req` is ignored in ALERT.
- In ALERT: `disp_value` shows the current alert code and `blank`=0.
- `alert_req` during ALERT:
  - Pending slot empty: the code is stored in the pending slot and `alert_ack` pulses.
  - Pending slot full: `alert_drop` pulses, with no ack, and the slot is unchanged.
- Alert expiry: when the tick arrives with the alert timer at `ALERT_TICKS`-1:
  - If the pending slot is valid, the pending code becomes current, the slot empties, the timer restarts, and the state stays ALERT.
  - Otherwise the state returns to SHOW, with the same `page_sel` and the page timer resuming from its frozen value.
- Expiry and `alert_req` in the same cycle:
  - Pending empty: the incoming code becomes current, with ack.
  - Pending full: the pending code becomes current and the incoming code is stored as pending, with ack.
  - No drop occurs in either case.
- `rst` outranks `en`, and `en`=0 outranks all requests.

## Timing
- `disp_value` tracks the current source with 1-cycle latency, re-sampled every cycle in SHOW. The alert code is stable throughout ALERT.
- Page change: `page_sel` updates on the clock edge after the tick or `next_req` cycle. `disp_value` follows one cycle later.
- Alert acceptance: `alert_ack`, `alert_active` and `disp_value`=code are all valid on the edge after the `alert_req` cycle.
- On `en` falling: `blank`=1 on the next edge.
- Page dwell: `PAGE_TICKS`×`TICK_DIV` cycles. Alert dwell: `ALERT_TICKS`×`TICK_DIV` cycles.
- Timer widths must hold the parameter values with no overflow. `PAGE_TICKS`, `ALERT_TICKS` and `TICK_DIV` are all ≥1.

## Test plan
All scenarios use `TICK_DIV`=4, `PAGE_TICKS`=3, `ALERT_TICKS`=2.
- Reset, then `en`=1 with `page_mask`=7'b0000101 and `combo`=42 → `page_sel`=0 and `disp_value`=42; after 12 cycles `page_sel`=2; after 12 more cycles `page_sel`=0.
- `next_req` pulse in the same cycle as a page timeout, `page_mask`=7'h7F, `page_sel`=3 → `page_sel`=4, not 5; the page timer restarts from 0.
- `alert_req` with code 999 mid-page → ack pulse, `alert_active`=1 and `disp_value`=999 for 8 cycles, then the same page returns and finishes its remaining dwell.
- Three `alert_req` pulses (codes 1, 2, 3) inside one alert → acks for 1 and 2, drop for 3; 1 is shown for 8 cycles, then 2 for 8 cycles, then SHOW resumes.
- `page_mask`=0 → `blank`=1 and `page_sel` holds; `mod`=2'b11 on page 4 → `disp_value`=3.
- `en` dropped during ALERT with a pending code, then raised again → `blank`=1 and `alert_active`=0; the pending code is lost; on re-enable `page_sel` is the lowest enabled page.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler: sequences the 8-digit scoreboard display. Statistic pages
// rotate on a tick-based timer or on a manual advance pulse. Timed alerts
// pre-empt the rotation and are buffered one deep.
module display_scheduler #(
  parameter int unsigned TICK_DIV    = 200000,
  parameter int unsigned PAGE_TICKS  = 1000,
  parameter int unsigned ALERT_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  page_mask,
  input  logic        next_req,
  input  logic        alert_req,
  input  logic [20:0] alert_code,
  input  logic [20:0] combo,
  input  logic [20:0] base_score,
  input  logic [20:0] bonus_score,
  input  logic [20:0] acc,
  input  logic [1:0]  mod,
  input  logic [3:0]  difficulty,
  input  logic [2:0]  level,
  output logic [20:0] disp_value,
  output logic [2:0]  page_sel,
  output logic        alert_active,
  output logic        blank,
  output logic        alert_ack,
  output logic        alert_drop
);

  localparam int unsigned TW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int unsigned PW = (PAGE_TICKS  > 1) ? $clog2(PAGE_TICKS)  : 1;
  localparam int unsigned AW = (ALERT_TICKS > 1) ? $clog2(ALERT_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_TICKS - 1);
  localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_TICKS - 1);

  typedef enum logic [1:0] {OFF, SHOW, ALERT} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] ptmr_q, ptmr_d;
  logic [AW-1:0] atmr_q, atmr_d;
  logic [2:0]    page_q, page_d;
  logic [20:0]   cur_q, cur_d;
  logic [20:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [20:0]   disp_q, disp_d;
  logic          active_q, active_d;
  logic          blank_q, blank_d;
  logic          ack_q, ack_d;
  logic          drop_q, drop_d;

  logic [20:0]   page_val;
  logic          tick;
  logic          page_to;
  logic          alert_to;

  // Lowest enabled page, or 0 when nothing is enabled.
  function automatic logic [2:0] first_page(input logic [6:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (mask[6 - i]) res = 3'(6 - i);
    end
    return res;
  endfunction

  // Next enabled page above cur, wrapping 6->0; cur itself is the last candidate.
  function automatic logic [2:0] next_page(input logic [2:0] cur, input logic [6:0] mask);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    idx   = cur;
    res   = cur;
    found = 1'b0;
    for (int unsigned k = 0; k < 7; k++) begin
      idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Source value of the currently selected page, zero-extended.
  always_comb begin
    page_val = '0;
    case (page_q)
      3'd0:    page_val = combo;
      3'd1:    page_val = base_score;
      3'd2:    page_val = bonus_score;
      3'd3:    page_val = acc;
      3'd4:    page_val = {19'd0, mod};
      3'd5:    page_val = {17'd0, difficulty};
      3'd6:    page_val = {18'd0, level};
      default: page_val = '0;
    endcase
  end

  // Next-state and output logic for the OFF/SHOW/ALERT sequencer.
  always_comb begin
    tick     = (tick_q == TICK_LAST);
    page_to  = tick && (ptmr_q == PAGE_LAST);
    alert_to = tick && (atmr_q == ALERT_LAST);

    state_d    = state_q;
    tick_d     = tick ? '0 : tick_q + 1'b1;
    ptmr_d     = ptmr_q;
    atmr_d     = atmr_q;
    page_d     = page_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    active_d   = active_q;
    blank_d    = blank_q;
    ack_d      = 1'b0;
    drop_d     = 1'b0;

    if (!en) begin
      state_d    = OFF;
      tick_d     = '0;
      ptmr_d     = '0;
      atmr_d     = '0;
      pend_vld_d = 1'b0;
      active_d   = 1'b0;
      blank_d    = 1'b1;
      disp_d     = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = SHOW;
          tick_d  = '0;
          ptmr_d  = '0;
          atmr_d  = '0;
          page_d  = first_page(page_mask);
          blank_d = (page_mask == '0);
        end
        SHOW: begin
          if (alert_req) begin
            // Tick phase restarts so the alert dwell is exact; the partial
            // tick already spent on the page is discarded.
            state_d  = ALERT;
            cur_d    = alert_code;
            ack_d    = 1'b1;
            atmr_d   = '0;
            tick_d   = '0;
            active_d = 1'b1;
            blank_d  = 1'b0;
            disp_d   = alert_code;
          end else begin
            disp_d  = page_val;
            blank_d = (page_mask == '0);
            if (next_req || page_to) begin
              page_d = next_page(page_q, page_mask);
              ptmr_d = '0;
            end else if (tick) begin
              ptmr_d = ptmr_q + 1'b1;
            end
          end
        end
        ALERT: begin
          if (alert_to) begin
            atmr_d = '0;
            if (alert_req) begin
              ack_d = 1'b1;
              if (pend_vld_q) begin
                cur_d  = pend_q;
                pend_d = alert_code;
              end else begin
                cur_d = alert_code;
              end
            end else if (pend_vld_q) begin
              cur_d      = pend_q;
              pend_vld_d = 1'b0;
            end else begin
              state_d  = SHOW;
              active_d = 1'b0;
            end
          end else begin
            if (tick) atmr_d = atmr_q + 1'b1;
            if (alert_req) begin
              if (!pend_vld_q) begin
                pend_d     = alert_code;
                pend_vld_d = 1'b1;
                ack_d      = 1'b1;
              end else begin
                drop_d = 1'b1;
              end
            end
          end
          if (state_d == ALERT) begin
            disp_d  = cur_d;
            blank_d = 1'b0;
          end else begin
            disp_d  = page_val;
            blank_d = (page_mask == '0);
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      tick_q     <= '0;
      ptmr_q     <= '0;
      atmr_q     <= '0;
      page_q     <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      active_q   <= 1'b0;
      blank_q    <= 1'b1;
      ack_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      ptmr_q     <= ptmr_d;
      atmr_q     <= atmr_d;
      page_q     <= page_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      active_q   <= active_d;
      blank_q    <= blank_d;
      ack_q      <= ack_d;
      drop_q     <= drop_d;
    end
  end

  assign disp_value   = disp_q;
  assign page_sel     = page_q;
  assign alert_active = active_q;
  assign blank        = blank_q;
  assign alert_ack    = ack_q;
  assign alert_drop   = drop_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed stimulus against a queue-based behavioural
// model of the display scheduler, compared every cycle, plus literal pins.
module tb_display_scheduler;

  localparam int unsigned TD = 4;
  localparam int unsigned PT = 3;
  localparam int unsigned AT = 2;

  logic        clk = 1'b0;
  logic        rst, en, next_req, alert_req;
  logic [6:0]  page_mask;
  logic [20:0] alert_code, combo, base_score, bonus_score, acc;
  logic [1:0]  mod;
  logic [3:0]  difficulty;
  logic [2:0]  level;
  logic [20:0] disp_value;
  logic [2:0]  page_sel;
  logic        alert_active, blank, alert_ack, alert_drop;

  display_scheduler #(.TICK_DIV(TD), .PAGE_TICKS(PT), .ALERT_TICKS(AT)) dut (
    .clk(clk), .rst(rst), .en(en), .page_mask(page_mask), .next_req(next_req),
    .alert_req(alert_req), .alert_code(alert_code), .combo(combo),
    .base_score(base_score), .bonus_score(bonus_score), .acc(acc), .mod(mod),
    .difficulty(difficulty), .level(level), .disp_value(disp_value),
    .page_sel(page_sel), .alert_active(alert_active), .blank(blank),
    .alert_ack(alert_ack), .alert_drop(alert_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: alert queue (front = shown, second = pending),
  // cycle phase since the last tick restart, page/alert tick counts.
  logic [20:0] aq[$];
  bit          m_on;
  int          m_phase, m_pt, m_at, m_page;
  logic [20:0] m_disp;
  bit          m_blank, m_ack, m_drop;

  function automatic logic [20:0] src(input int p);
    case (p)
      0: return combo;
      1: return base_score;
      2: return bonus_score;
      3: return acc;
      4: return 21'(mod);
      5: return 21'(difficulty);
      default: return 21'(level);
    endcase
  endfunction

  function automatic int low(input logic [6:0] m);
    for (int i = 0; i < 7; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int adv(input int p, input logic [6:0] m);
    for (int k = 1; k <= 7; k++) if (m[(p + k) % 7]) return (p + k) % 7;
    return p;
  endfunction

  task automatic model_step();
    bit tick, expire;
    int old_page;
    m_ack = 1'b0;
    m_drop = 1'b0;
    if (rst) begin
      m_on = 0; aq.delete(); m_phase = 0; m_pt = 0; m_at = 0;
      m_page = 0; m_disp = '0; m_blank = 1'b1;
    end else if (!en) begin
      m_on = 0; aq.delete(); m_phase = 0; m_pt = 0; m_at = 0;
      m_disp = '0; m_blank = 1'b1;
    end else if (!m_on) begin
      m_on = 1; m_page = low(page_mask); m_phase = 0; m_pt = 0; m_at = 0;
      m_blank = (page_mask == 7'd0);
    end else begin
      old_page = m_page;
      tick = ((m_phase % TD) == TD - 1);
      m_phase++;
      if (aq.size() == 0) begin
        if (alert_req) begin
          aq.push_back(alert_code); m_ack = 1'b1; m_at = 0; m_phase = 0;
        end else if (next_req || (tick && m_pt == PT - 1)) begin
          m_page = adv(m_page, page_mask); m_pt = 0;
        end else if (tick) begin
          m_pt++;
        end
      end else begin
        expire = tick && (m_at == AT - 1);
        if (alert_req) begin
          if (aq.size() < 2 || expire) begin
            aq.push_back(alert_code); m_ack = 1'b1;
          end else begin
            m_drop = 1'b1;
          end
        end
        if (expire) begin
          void'(aq.pop_front()); m_at = 0;
        end else if (tick) begin
          m_at++;
        end
      end
      if (aq.size() == 0) begin
        m_disp = src(old_page); m_blank = (page_mask == 7'd0);
      end else begin
        m_disp = aq[0]; m_blank = 1'b0;
      end
    end
  endtask

  // Advance the model on every active edge.
  always @(posedge clk) model_step();

  // Compare every DUT output against the model on the inactive edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_disp_value",   32'(disp_value),   32'(m_disp));
      chk("m_page_sel",     32'(page_sel),     32'(m_page));
      chk("m_alert_active", 32'(alert_active), 32'(aq.size() != 0));
      chk("m_blank",        32'(blank),        32'(m_blank));
      chk("m_alert_ack",    32'(alert_ack),    32'(m_ack));
      chk("m_alert_drop",   32'(alert_drop),   32'(m_drop));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; next_req = 1'b0; alert_req = 1'b0;
    page_mask = 7'b0000101; alert_code = '0;
    combo = 21'd42; base_score = 21'd100; bonus_score = 21'd200; acc = 21'd300;
    mod = 2'b11; difficulty = 4'd9; level = 3'd5;

    cyc(1);
    cmp_on = 1'b1;
    chk("rst_page", 32'(page_sel), 0);
    chk("rst_disp", 32'(disp_value), 0);
    chk("rst_blank", 32'(blank), 1);
    chk("rst_active", 32'(alert_active), 0);
    chk("rst_ack", 32'(alert_ack), 0);
    chk("rst_drop", 32'(alert_drop), 0);

    // Rotation over pages 0 and 2.
    cyc(1); rst = 1'b0; en = 1'b1;
    cyc(1);  chk("on_page", 32'(page_sel), 0);
    cyc(1);  chk("on_disp", 32'(disp_value), 42);
    cyc(10); chk("p0_last", 32'(page_sel), 0);
    cyc(1);  chk("p2_first", 32'(page_sel), 2);
    cyc(11); chk("p2_last", 32'(page_sel), 2);
    cyc(1);  chk("wrap_p0", 32'(page_sel), 0);
    page_mask = 7'h7F;

    // next_req coinciding with the page 3 timeout.
    cyc(47); chk("pre_nr", 32'(page_sel), 3); next_req = 1'b1;
    cyc(1);  next_req = 1'b0; chk("nr_once", 32'(page_sel), 4);
    cyc(11); chk("nr_restart", 32'(page_sel), 4);
    cyc(1);  chk("nr_next", 32'(page_sel), 5);

    // Alert 999 mid-page.
    cyc(5);  alert_req = 1'b1; alert_code = 21'd999;
    cyc(1);  alert_req = 1'b0;
    chk("a_ack", 32'(alert_ack), 1);
    chk("a_active", 32'(alert_active), 1);
    chk("a_disp", 32'(disp_value), 999);
    cyc(7);  chk("a_last", 32'(disp_value), 999);
    cyc(1);  chk("a_end_active", 32'(alert_active), 0);
    chk("a_end_page", 32'(page_sel), 5);
    chk("a_end_disp", 32'(disp_value), 9);
    cyc(7);  chk("remain_last", 32'(page_sel), 5);
    cyc(1);  chk("remain_next", 32'(page_sel), 6);

    // Three alerts back to back: 1 shown, 2 queued, 3 dropped.
    alert_req = 1'b1; alert_code = 21'd1;
    cyc(1); alert_code = 21'd2;
    chk("q1_ack", 32'(alert_ack), 1); chk("q1_disp", 32'(disp_value), 1);
    cyc(1); alert_code = 21'd3;
    chk("q2_ack", 32'(alert_ack), 1);
    cyc(1); alert_req = 1'b0;
    chk("q3_drop", 32'(alert_drop), 1); chk("q3_noack", 32'(alert_ack), 0);
    cyc(5); chk("q1_last", 32'(disp_value), 1);
    cyc(1); chk("q2_first", 32'(disp_value), 2);
    cyc(7); chk("q2_last", 32'(disp_value), 2);
    cyc(1); chk("q_end_active", 32'(alert_active), 0);
    chk("q_end_disp", 32'(disp_value), 5);
    page_mask = 7'd0;

    // Empty mask blanks and holds; mod shown on page 4.
    cyc(1);  chk("m0_blank", 32'(blank), 1); chk("m0_page", 32'(page_sel), 6);
    cyc(12); chk("m0_hold", 32'(page_sel), 6); next_req = 1'b1;
    cyc(1);  next_req = 1'b0; page_mask = 7'b0010000;
    chk("m0_nr_hold", 32'(page_sel), 6);
    cyc(1);  next_req = 1'b1; chk("m4_unblank", 32'(blank), 0);
    cyc(1);  next_req = 1'b0; chk("m4_page", 32'(page_sel), 4);
    cyc(1);  chk("mod_disp", 32'(disp_value), 3);

    // en dropped during an alert with a pending code.
    alert_req = 1'b1; alert_code = 21'd77;
    cyc(1); alert_code = 21'd88; chk("e_disp", 32'(disp_value), 77);
    cyc(1); alert_req = 1'b0; en = 1'b0; chk("e_pend_ack", 32'(alert_ack), 1);
    cyc(1); chk("off_blank", 32'(blank), 1); chk("off_active", 32'(alert_active), 0);
    alert_req = 1'b1; alert_code = 21'd55;
    cyc(1); alert_req = 1'b0; chk("off_noack", 32'(alert_ack), 0);
    cyc(1); en = 1'b1; page_mask = 7'b0101000;
    cyc(1); chk("re_page", 32'(page_sel), 3); chk("re_active", 32'(alert_active), 0);
    cyc(20); chk("re_no_pend", 32'(alert_active), 0);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
